guess_game_sequencer: RTL and testbench

//  Central sequencer for the 4-digit guess-number game. Takes decoded keypad events and sequences
//  the game: secret (question) entry, guess entry, scoring and the win/restart flow.

---
 rtl/guess_pkg.sv | 30 +++
 rtl/guess_game_sequencer_ab_scorer.sv | 38 +++
 rtl/guess_game_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_guess_game_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number game sequencer.
// FSM state encoding, key codes, entry geometry and a pointer-to-mask helper.
package guess_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int ENTRY_W    = DIGIT_W * NUM_DIGITS;

    localparam logic [DIGIT_W-1:0] KEY_CODE_CLEAR = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_CODE_ENTER = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_CODE_MAXD  = 4'd9;

    typedef enum logic [2:0] {
        SET_Q = 3'd0,
        GUESS = 3'd1,
        SCORE = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } fsm_state_t;

    // Positions already holding a digit: everything below the one-hot pointer,
    // or all of them once the pointer has shifted out (entry full).
    function automatic logic [NUM_DIGITS-1:0] filled_mask(input logic [NUM_DIGITS-1:0] ptr);
        if (ptr == '0)
            return '1;
        else
            return ptr - 1'b1;
    endfunction

endpackage

// File: rtl/guess_game_sequencer_ab_scorer.sv
// ab_scorer: combinational bulls/cows count of a guess against the question.
// Digits within each word are assumed unique.
module ab_scorer
    import guess_pkg::*;
(
    input  logic [ENTRY_W-1:0] i_q_digits,
    input  logic [ENTRY_W-1:0] i_g_digits,
    output logic [2:0]         o_a_cnt,
    output logic [2:0]         o_b_cnt
);

    // w_match[qi][gj]: question digit qi equals guess digit gj
    logic [NUM_DIGITS-1:0] w_match [NUM_DIGITS];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_q
            for (gj = 0; gj < NUM_DIGITS; gj++) begin : g_g
                assign w_match[gi][gj] =
                    (i_q_digits[gi*DIGIT_W +: DIGIT_W] == i_g_digits[gj*DIGIT_W +: DIGIT_W]);
            end
        end
    endgenerate

    always_comb begin
        o_a_cnt = 3'd0;
        o_b_cnt = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (i == j)
                    o_a_cnt = o_a_cnt + {2'b00, w_match[i][j]};
                else
                    o_b_cnt = o_b_cnt + {2'b00, w_match[i][j]};
            end
        end
    end

endmodule

// File: rtl/guess_game_sequencer.sv
// Guess-number game sequencer: question entry, guess entry, xAyB scoring, win/restart.
// Optional GUESS_ATTEMPT_LIMIT_EN adds a LOSE state after MAX_ATTEMPTS wrong guesses.
module guess_game_sequencer
    import guess_pkg::*;
#(
    parameter int                 ATTEMPT_W    = 7,
    parameter int                 MAX_ATTEMPTS = 10,
    parameter logic [DIGIT_W-1:0] KEY_CLEAR    = KEY_CODE_CLEAR,
    parameter logic [DIGIT_W-1:0] KEY_ENTER    = KEY_CODE_ENTER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [DIGIT_W-1:0]    key_code,
    output logic                  state,
    output logic [NUM_DIGITS-1:0] digit,
    output logic [ENTRY_W-1:0]    q_digits,
    output logic [ENTRY_W-1:0]    g_digits,
    output logic                  result_valid,
    output logic [2:0]            a_cnt,
    output logic [2:0]            b_cnt,
    output logic [ATTEMPT_W-1:0]  attempts,
    output logic                  win,
    output logic                  lose,
    output logic                  key_err
);

    localparam logic [ATTEMPT_W-1:0] ATTEMPT_SAT = ATTEMPT_W'(99);

    fsm_state_t              r_state_reg, w_state_next;
    logic [NUM_DIGITS-1:0]   r_digit_reg, w_digit_next;
    logic [ENTRY_W-1:0]      r_q_reg, w_q_next;
    logic [ENTRY_W-1:0]      r_g_reg, w_g_next;
    logic [2:0]              r_a_reg, w_a_next;
    logic [2:0]              r_b_reg, w_b_next;
    logic [ATTEMPT_W-1:0]    r_attempts_reg, w_attempts_next;
    logic                    r_rv_reg, w_rv_next;
    logic                    r_err_reg, w_err_next;
    logic                    r_state_bit_reg;
    logic                    r_win_reg;

    logic [ENTRY_W-1:0]      w_entry;
    logic [ENTRY_W-1:0]      w_entry_wr;
    logic [NUM_DIGITS-1:0]   w_filled;
    logic [NUM_DIGITS-1:0]   w_dup_vec;
    logic                    w_dup;
    logic                    w_full;
    logic                    w_is_digit;
    logic [2:0]              w_score_a;
    logic [2:0]              w_score_b;
    logic [ATTEMPT_W-1:0]    w_attempts_inc;

    ab_scorer u_scorer (
        .i_q_digits (r_q_reg),
        .i_g_digits (r_g_reg),
        .o_a_cnt    (w_score_a),
        .o_b_cnt    (w_score_b)
    );

    assign w_entry        = (r_state_reg == SET_Q) ? r_q_reg : r_g_reg;
    assign w_full         = (r_digit_reg == '0);
    assign w_filled       = filled_mask(r_digit_reg);
    assign w_is_digit     = (key_code <= KEY_CODE_MAXD);
    assign w_dup          = |w_dup_vec;
    assign w_attempts_inc = (r_attempts_reg >= ATTEMPT_SAT) ? r_attempts_reg
                                                            : r_attempts_reg + 1'b1;

    // Stale digits beyond the pointer (after CLEAR or a rescored guess) must not count as duplicates.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            assign w_dup_vec[gi] = w_filled[gi] &&
                                   (w_entry[gi*DIGIT_W +: DIGIT_W] == key_code);
            assign w_entry_wr[gi*DIGIT_W +: DIGIT_W] =
                r_digit_reg[gi] ? key_code : w_entry[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state_reg;
        w_digit_next    = r_digit_reg;
        w_q_next        = r_q_reg;
        w_g_next        = r_g_reg;
        w_a_next        = r_a_reg;
        w_b_next        = r_b_reg;
        w_attempts_next = r_attempts_reg;
        w_rv_next       = 1'b0;
        w_err_next      = 1'b0;

        case (r_state_reg)
            SET_Q, GUESS: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (w_full || w_dup) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_digit_next = r_digit_reg << 1;
                            if (r_state_reg == SET_Q)
                                w_q_next = w_entry_wr;
                            else
                                w_g_next = w_entry_wr;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_digit_next = 4'b0001;
                        if (r_state_reg == SET_Q)
                            w_q_next = '0;
                        else
                            w_g_next = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (!w_full) begin
                            w_err_next = 1'b1;
                        end else if (r_state_reg == SET_Q) begin
                            w_state_next    = GUESS;
                            w_g_next        = '0;
                            w_digit_next    = 4'b0001;
                            w_attempts_next = '0;
                        end else begin
                            // Score is captured on entry so result_valid is high during SCORE.
                            w_state_next    = SCORE;
                            w_a_next        = w_score_a;
                            w_b_next        = w_score_b;
                            w_rv_next       = 1'b1;
                            w_attempts_next = w_attempts_inc;
                        end
                    end
                end
            end
            SCORE: begin
                if (r_a_reg == 3'd4) begin
                    w_state_next = WIN;
                end else begin
`ifdef GUESS_ATTEMPT_LIMIT_EN
                    if (r_attempts_reg == ATTEMPT_W'(MAX_ATTEMPTS)) begin
                        w_state_next = LOSE;
                    end else begin
                        w_state_next = GUESS;
                        w_digit_next = 4'b0001;
                    end
`else
                    w_state_next = GUESS;
                    w_digit_next = 4'b0001;
`endif
                end
            end
            WIN, LOSE: begin
                if (key_valid && (key_code == KEY_ENTER)) begin
                    w_state_next = SET_Q;
                    w_q_next     = '0;
                    w_g_next     = '0;
                    w_digit_next = 4'b0001;
                end
            end
            default: begin
                w_state_next = SET_Q;
                w_digit_next = 4'b0001;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg     <= SET_Q;
            r_digit_reg     <= 4'b0001;
            r_q_reg         <= '0;
            r_g_reg         <= '0;
            r_a_reg         <= '0;
            r_b_reg         <= '0;
            r_attempts_reg  <= '0;
            r_rv_reg        <= 1'b0;
            r_err_reg       <= 1'b0;
            r_state_bit_reg <= 1'b0;
            r_win_reg       <= 1'b0;
        end else begin
            r_state_reg     <= w_state_next;
            r_digit_reg     <= w_digit_next;
            r_q_reg         <= w_q_next;
            r_g_reg         <= w_g_next;
            r_a_reg         <= w_a_next;
            r_b_reg         <= w_b_next;
            r_attempts_reg  <= w_attempts_next;
            r_rv_reg        <= w_rv_next;
            r_err_reg       <= w_err_next;
            r_state_bit_reg <= (w_state_next != SET_Q);
            r_win_reg       <= (w_state_next == WIN);
        end
    end

`ifdef GUESS_ATTEMPT_LIMIT_EN
    logic r_lose_reg;
    always_ff @(posedge clk) begin
        if (rst)
            r_lose_reg <= 1'b0;
        else
            r_lose_reg <= (w_state_next == LOSE);
    end
    assign lose = r_lose_reg;
`else
    assign lose = 1'b0;
`endif

    assign state        = r_state_bit_reg;
    assign digit        = r_digit_reg;
    assign q_digits     = r_q_reg;
    assign g_digits     = r_g_reg;
    assign result_valid = r_rv_reg;
    assign a_cnt        = r_a_reg;
    assign b_cnt        = r_b_reg;
    assign attempts     = r_attempts_reg;
    assign win          = r_win_reg;
    assign key_err      = r_err_reg;

endmodule

// File: tb/tb_guess_game_sequencer.sv
// Directed bench for guess_game_sequencer: entry vector table plus scoring/win/reset sequences.
// Define GUESS_ATTEMPT_LIMIT_EN on both DUT and bench to exercise the lockout path.
module tb_guess_game_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        state;
    logic [3:0]  digit;
    logic [15:0] q_digits;
    logic [15:0] g_digits;
    logic        result_valid;
    logic [2:0]  a_cnt;
    logic [2:0]  b_cnt;
    logic [6:0]  attempts;
    logic        win;
    logic        lose;
    logic        key_err;

    int n_checks = 0;
    int n_errors = 0;

    guess_game_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .state        (state),
        .digit        (digit),
        .q_digits     (q_digits),
        .g_digits     (g_digits),
        .result_valid (result_valid),
        .a_cnt        (a_cnt),
        .b_cnt        (b_cnt),
        .attempts     (attempts),
        .win          (win),
        .lose         (lose),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic        err;
        logic [3:0]  dig;
        logic        st;
        logic [15:0] q;
        logic [15:0] g;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Key is sampled by exactly one rising edge; returns on the following falling edge.
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        $display("key %h -> state=%0d digit=%b q=%h g=%h err=%0d rv=%0d a=%0d b=%0d att=%0d",
                 c, state, digit, q_digits, g_digits, key_err, result_valid, a_cnt, b_cnt, attempts);
    endtask

    task automatic enter_word(input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic [3:0] d4);
        press(d1);
        press(d2);
        press(d3);
        press(d4);
        press(4'hB);
    endtask

    initial begin
        // Entry behaviour from reset: question entry, then guess entry with errors.
        vecs[0]  = '{4'h1, 1'b0, 4'b0010, 1'b0, 16'h0001, 16'h0000};
        vecs[1]  = '{4'h2, 1'b0, 4'b0100, 1'b0, 16'h0021, 16'h0000};
        vecs[2]  = '{4'h3, 1'b0, 4'b1000, 1'b0, 16'h0321, 16'h0000};
        vecs[3]  = '{4'h4, 1'b0, 4'b0000, 1'b0, 16'h4321, 16'h0000};
        vecs[4]  = '{4'h5, 1'b1, 4'b0000, 1'b0, 16'h4321, 16'h0000};
        vecs[5]  = '{4'hB, 1'b0, 4'b0001, 1'b1, 16'h4321, 16'h0000};
        vecs[6]  = '{4'h5, 1'b0, 4'b0010, 1'b1, 16'h4321, 16'h0005};
        vecs[7]  = '{4'h5, 1'b1, 4'b0010, 1'b1, 16'h4321, 16'h0005};
        vecs[8]  = '{4'h6, 1'b0, 4'b0100, 1'b1, 16'h4321, 16'h0065};
        vecs[9]  = '{4'h7, 1'b0, 4'b1000, 1'b1, 16'h4321, 16'h0765};
        vecs[10] = '{4'hB, 1'b1, 4'b1000, 1'b1, 16'h4321, 16'h0765};
        vecs[11] = '{4'hC, 1'b0, 4'b1000, 1'b1, 16'h4321, 16'h0765};
        vecs[12] = '{4'hA, 1'b0, 4'b0001, 1'b1, 16'h4321, 16'h0000};
        vecs[13] = '{4'h0, 1'b0, 4'b0010, 1'b1, 16'h4321, 16'h0000};
        vecs[14] = '{4'h0, 1'b1, 4'b0010, 1'b1, 16'h4321, 16'h0000};
        vecs[15] = '{4'hA, 1'b0, 4'b0001, 1'b1, 16'h4321, 16'h0000};

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_state",    {31'd0, state},        32'd0);
        chk("rst_digit",    {28'd0, digit},        32'h1);
        chk("rst_q",        {16'd0, q_digits},     32'h0);
        chk("rst_g",        {16'd0, g_digits},     32'h0);
        chk("rst_ab",       {26'd0, a_cnt, b_cnt}, 32'h0);
        chk("rst_attempts", {25'd0, attempts},     32'h0);
        chk("rst_flags",    {27'd0, result_valid, win, lose, key_err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d_err", i),   {31'd0, key_err},  {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_digit", i), {28'd0, digit},    {28'd0, vecs[i].dig});
            chk($sformatf("vec%0d_state", i), {31'd0, state},    {31'd0, vecs[i].st});
            chk($sformatf("vec%0d_q", i),     {16'd0, q_digits}, {16'd0, vecs[i].q});
            chk($sformatf("vec%0d_g", i),     {16'd0, g_digits}, {16'd0, vecs[i].g});
        end
        chk("entry_attempts", {25'd0, attempts}, 32'd0);

        // Guess g=1234 vs q=4321: no bulls, four cows. Pulse is visible during SCORE.
        enter_word(4'h4, 4'h3, 4'h2, 4'h1);
        chk("s1_rv",       {31'd0, result_valid}, 32'd1);
        chk("s1_a",        {29'd0, a_cnt},        32'd0);
        chk("s1_b",        {29'd0, b_cnt},        32'd4);
        chk("s1_attempts", {25'd0, attempts},     32'd1);
        @(negedge clk);
        chk("s1_rv_drop",  {31'd0, result_valid}, 32'd0);
        chk("s1_digit",    {28'd0, digit},        32'h1);
        chk("s1_g_kept",   {16'd0, g_digits},     32'h1234);
        chk("s1_win",      {31'd0, win},          32'd0);

        // Guess g=5231 vs 4321: one bull (1), two cows (2,3).
        enter_word(4'h1, 4'h3, 4'h2, 4'h5);
        chk("s2_a",        {29'd0, a_cnt},    32'd1);
        chk("s2_b",        {29'd0, b_cnt},    32'd2);
        chk("s2_attempts", {25'd0, attempts}, 32'd2);

        // Exact guess -> WIN; other keys ignored there; ENTER restarts.
        enter_word(4'h1, 4'h2, 4'h3, 4'h4);
        chk("s3_a",        {29'd0, a_cnt},        32'd4);
        chk("s3_b",        {29'd0, b_cnt},        32'd0);
        chk("s3_rv",       {31'd0, result_valid}, 32'd1);
        @(negedge clk);
        chk("s3_win",      {31'd0, win},          32'd1);
        chk("s3_state",    {31'd0, state},        32'd1);
        chk("s3_attempts", {25'd0, attempts},     32'd3);
        press(4'h7);
        chk("win_key_err", {31'd0, key_err},      32'd0);
        chk("win_hold",    {31'd0, win},          32'd1);
        press(4'hB);
        chk("restart_state", {31'd0, state},    32'd0);
        chk("restart_q",     {16'd0, q_digits}, 32'h0);
        chk("restart_g",     {16'd0, g_digits}, 32'h0);
        chk("restart_digit", {28'd0, digit},    32'h1);
        chk("restart_win",   {31'd0, win},      32'd0);

        // Reset mid guess, with a key pending in the same cycle.
        enter_word(4'h9, 4'h8, 4'h7, 4'h6);
        press(4'h1);
        press(4'h2);
        chk("mid_digit", {28'd0, digit}, 32'h4);
        @(negedge clk);
        rst       = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h3;
        @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;
        chk("mrst_state", {31'd0, state},    32'd0);
        chk("mrst_digit", {28'd0, digit},    32'h1);
        chk("mrst_q",     {16'd0, q_digits}, 32'h0);
        chk("mrst_g",     {16'd0, g_digits}, 32'h0);
        chk("mrst_att",   {25'd0, attempts}, 32'h0);
        chk("mrst_flags", {27'd0, result_valid, win, lose, key_err}, 32'h0);

`ifdef GUESS_ATTEMPT_LIMIT_EN
        enter_word(4'h1, 4'h2, 4'h3, 4'h4);
        for (int n = 1; n <= 10; n++) begin
            enter_word(4'h5, 4'h6, 4'h7, 4'h8);
            chk($sformatf("lim%0d_att", n), {25'd0, attempts}, n);
            @(negedge clk);
            chk($sformatf("lim%0d_lose", n), {31'd0, lose}, (n == 10) ? 32'd1 : 32'd0);
        end
        chk("lose_q_reveal", {16'd0, q_digits}, 32'h4321);
        press(4'hB);
        chk("lose_exit_state", {31'd0, state}, 32'd0);
        chk("lose_exit_flag",  {31'd0, lose},  32'd0);
`else
        chk("lose_tied_low", {31'd0, lose}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
